signed_serial_divider: RTL and testbench
========================================

# signed_serial_divider

- Sequential signed divider; the inverse operation of the team's signed serial multiplier.
- Takes a 2·width-bit signed dividend `A` (typically a multiplier product `S`) and a width-bit signed divisor `B`. Produces a width-bit quotient and remainder, one restoring-division bit per clock.
- Uses the same `en`/`valid` handshake as the multiplier, so the two can be chained or tested back-to-back with one bench style.

## Interface
- `width`, default 10: divisor, quotient and remainder width; dividend is 2·width.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `en`  in  1: start pulse. Sampled only in IDLE or DONE.
- `A`  in  2·width, `[width*2:1]`: signed dividend.
- `B`  in  width, `[width:1]`: signed divisor.
- `valid`  out  1: result ready. Level; held until the next accepted `en`.
- `Q`  out  width: signed quotient.
- `R`  out  width: signed remainder.
- `ovf`  out  1: quotient not representable in width bits.
- `dbz`  out  1: divide by zero.

## Operation
- States:
  - IDLE: after reset.
  - CALC: division iterations.
  - FIX: sign correction and output register.
  - DONE: result held.
- Load (`en`=1 in IDLE/DONE):
  - Capture |A| and |B|, sign of A, and sign of A xor sign of B.
  - Clear the partial remainder; counter = 0; `valid` drops to 0.
  - If B==0: set `dbz`, go to FIX. Otherwise go to CALC.
- CALC performs 2·width restoring steps, MSB of |A| first:
  - Shift the partial remainder left and bring in the next dividend bit.
  - Trial-subtract |B|. If the result is non-negative, keep it and shift in a quotient bit of 1; otherwise restore and shift in 0.
  - After the 2·width-th step, go to FIX.
- Arithmetic rules:
  - Truncating (C) semantics: quotient rounds toward zero; R takes the sign of A; |R| < |B|.
  - The magnitude quotient is 2·width bits internally.
  - `ovf`=1 when the true quotient is greater than 2^(width-1)−1 or less than −2^(width-1). −2^(width-1) itself is legal.
- FIX: negate quotient and remainder as required, register `Q`/`R`/`ovf`/`dbz`, set `valid`=1, go to DONE.
- Divide by zero: Q=0, R=0, `dbz`=1, `ovf`=0.
- `en` during CALC or FIX is ignored. There is no queueing and no restart.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - `valid`=0, `Q`=0, `R`=0, `ovf`=0, `dbz`=0; internal registers cleared.
  - Reset mid-operation aborts the operation and produces no `valid`.
- Normal latency: with load at edge k, iterations occur on edges k+1 … k+2·width and `valid` rises on edge k+2·width+1. For width=10 that is 21 edges.
- Divide-by-zero latency: `valid` rises on edge k+1.
- Outputs are stable for as long as `valid`=1. On the next accepted `en`, `valid` falls on that same edge; `Q`/`R` hold their old values until FIX.
- `en` held high across DONE restarts immediately; no idle cycle is required.

## Configuration
- `SIGNED_DIV_SAT_EN` defined: on overflow, Q saturates to 2^(width-1)−1 (positive result) or −2^(width-1) (negative result). R is the true remainder.
- Not defined: on overflow, Q is the low width bits of the two's-complement true quotient (wraps).
- `ovf` is asserted in both builds.

## Structure
- Package `signed_serial_div_pkg` holds:
  - State enum (IDLE, CALC, FIX, DONE).
  - Counter-width localparam, $clog2(2·width+1).
  - Negate/abs helper functions.
- One combinational sub-module, `sdiv_restore_step`: one shift/trial-subtract/restore step. Inputs are partial remainder, dividend bit and |B|; outputs are next remainder and quotient bit.
- The FSM, counter and sign handling stay in the top module.

## Test plan
All cases at width=10.
- A=1000, B=7 → Q=142, R=6, ovf=0, dbz=0. `valid` rises exactly 21 edges after the load edge.
- Sign combinations:
  - A=−1000, B=7 → Q=−142, R=−6.
  - A=1000, B=−7 → Q=−142, R=6.
  - A=−1000, B=−7 → Q=142, R=−6.
- A=123, B=0 → dbz=1, Q=0, R=0. `valid` one edge after load.
- Overflow and boundary:
  - A=600, B=1 → ovf=1. With macro, Q=511. Without macro, Q=10'b1001011000 (−424).
  - A=−512, B=1 → Q=−512, ovf=0.
- Multiplier round trip: A=262144, B=−512 → Q=−512, R=0, ovf=0.
- Robustness:
  - `en` pulsed on CALC cycle 3 → ignored, result unchanged.
  - `rst_n` low on CALC cycle 5 → `valid`/Q/R go to 0 immediately. A fresh `en` afterwards completes correctly.

Source files
------------

// File: rtl/signed_serial_div_pkg.sv
// Shared types and helpers for the signed serial divider: FSM state encoding,
// counter sizing and two's-complement negate/abs on a wide scratch word.
package signed_serial_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_CNT_W = $clog2(2 * DEF_WIDTH + 1);

  // Helpers work on a 64-bit word; callers sign/zero-extend in and truncate out.
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

  function automatic word_t neg_w(input word_t x);
    return ~x + word_t'(1);
  endfunction

  function automatic word_t abs_w(input word_t x);
    return x[MAX_W-1] ? neg_w(x) : x;
  endfunction

endpackage

// File: rtl/sdiv_restore_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor magnitude, keep or restore.
module sdiv_restore_step
  import signed_serial_div_pkg::*;
#(
  parameter int width = 10
) (
  input  logic [width-1:0] rem_i,
  input  logic             bit_i,
  input  logic [width-1:0] bmag_i,
  output logic [width-1:0] rem_o,
  output logic             qbit_o
);

  logic [width:0]   shifted;
  logic [width+1:0] trial;
  logic             unused_top;

  // The remainder stays below |B| <= 2^(width-1), so the top bits carry no data.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = {1'b0, shifted} - {2'b00, bmag_i};
    qbit_o  = ~trial[width+1];
    rem_o   = qbit_o ? trial[width-1:0] : shifted[width-1:0];
  end

  assign unused_top = ^{trial[width], shifted[width]};

endmodule

// File: rtl/signed_serial_divider.sv
// Sequential signed restoring divider (2*width / width -> width quotient and remainder).
// Define SIGNED_DIV_SAT_EN to saturate the quotient on overflow instead of wrapping.
module signed_serial_divider
  import signed_serial_div_pkg::*;
#(
  parameter int width = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [width*2:1]   A,
  input  logic [width:1]     B,
  output logic               valid,
  output logic [width:1]     Q,
  output logic [width:1]     R,
  output logic               ovf,
  output logic               dbz
);

  localparam int DW = 2 * width;
  localparam int CW = cnt_width(width);
  localparam logic [DW-1:0] QLIM = DW'(1) << (width - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic [width-1:0]   rem_q, rem_d;
  logic [width-1:0]   bmag_q, bmag_d;
  logic               sa_q, sa_d;
  logic               sq_q, sq_d;
  logic               zero_q, zero_d;
  logic               valid_q, valid_d;
  logic [width-1:0]   q_q, q_d;
  logic [width-1:0]   r_q, r_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  logic signed [DW-1:0]    a_s;
  logic signed [width-1:0] b_s;
  logic [DW-1:0]           amag;
  logic [width-1:0]        bmag;
  logic [width-1:0]        step_rem;
  logic                    step_qbit;
  logic [width-1:0]        qneg_lo;
  logic [width-1:0]        rneg;
  logic                    ovf_calc;
  logic [width-1:0]        q_wrap;
  logic [width-1:0]        q_sat;

  assign a_s  = A;
  assign b_s  = B;
  assign amag = DW'(abs_w(word_t'(a_s)));
  assign bmag = width'(abs_w(word_t'(b_s)));

  // acc_q starts as |A| and, bit by bit, turns into the magnitude quotient.
  sdiv_restore_step #(
    .width (width)
  ) u_step (
    .rem_i  (rem_q),
    .bit_i  (acc_q[DW-1]),
    .bmag_i (bmag_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  assign qneg_lo  = width'(neg_w(word_t'(acc_q)));
  assign rneg     = width'(neg_w(word_t'(rem_q)));
  // A negative result may reach magnitude 2^(width-1); a positive one may not.
  assign ovf_calc = sq_q ? (acc_q > QLIM) : (acc_q >= QLIM);
  assign q_wrap   = sq_q ? qneg_lo : acc_q[width-1:0];
  assign q_sat    = sq_q ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    sa_d    = sa_q;
    sq_d    = sq_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (en) begin
          acc_d   = amag;
          bmag_d  = bmag;
          sa_d    = a_s[DW-1];
          sq_d    = a_s[DW-1] ^ b_s[width-1];
          rem_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          zero_d  = (B == '0);
          state_d = (B == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        acc_d = {acc_q[DW-2:0], step_qbit};
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (zero_q) begin
          q_d   = '0;
          r_d   = '0;
          ovf_d = 1'b0;
          dbz_d = 1'b1;
        end else begin
`ifdef SIGNED_DIV_SAT_EN
          q_d = ovf_calc ? q_sat : q_wrap;
`else
          q_d = q_wrap;
`endif
          r_d   = sa_q ? rneg : rem_q;
          ovf_d = ovf_calc;
          dbz_d = 1'b0;
        end
        valid_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef SIGNED_DIV_SAT_EN
  logic unused_sat;
  assign unused_sat = ^q_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      sa_q    <= 1'b0;
      sq_q    <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      sa_q    <= sa_d;
      sq_q    <= sq_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign valid = valid_q;
  assign Q     = q_q;
  assign R     = r_q;
  assign ovf   = ovf_q;
  assign dbz   = dbz_q;

endmodule

// File: tb/tb_signed_serial_divider.sv
// Self-checking bench for signed_serial_divider at width=10: integer-arithmetic
// model compared every cycle, plus directed vectors with literal expectations.
module tb_signed_serial_divider;

  localparam int     W    = 10;
  localparam longint MAXQ = 511;
  localparam longint MINQ = -512;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           en    = 1'b0;
  logic [2*W:1]   A     = '0;
  logic [W:1]     B     = '0;
  logic           valid;
  logic [W:1]     Q;
  logic [W:1]     R;
  logic           ovf;
  logic           dbz;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  bit     m_busy  = 1'b0;
  bit     m_valid = 1'b0;
  int     m_left  = 0;
  longint m_q = 0, m_r = 0;
  bit     m_ovf = 1'b0, m_dbz = 1'b0;
  longint p_q = 0, p_r = 0;
  bit     p_ovf = 1'b0, p_dbz = 1'b0;

  signed_serial_divider #(.width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .B     (B),
    .valid (valid),
    .Q     (Q),
    .R     (R),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sxw(input logic [W:1] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sx2w(input logic [2*W:1] v);
    return longint'($signed(v));
  endfunction

  // Truncating division as plain integer arithmetic.
  function automatic void model(input longint a, input longint b,
                                output longint q, output longint r,
                                output bit ov, output bit dz);
    longint tq;
    if (b == 0) begin
      q = 0; r = 0; ov = 1'b0; dz = 1'b1;
    end else begin
      tq = a / b;
      r  = a % b;
      ov = (tq > MAXQ) || (tq < MINQ);
      dz = 1'b0;
`ifdef SIGNED_DIV_SAT_EN
      q = ov ? ((tq > 0) ? MAXQ : MINQ) : tq;
`else
      q = ((tq % 1024) + 1024) % 1024;
      if (q >= 512) q = q - 1024;
`endif
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0; m_left = 0;
      m_q = 0; m_r = 0; m_ovf = 1'b0; m_dbz = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_valid = 1'b1;
        m_q = p_q; m_r = p_r; m_ovf = p_ovf; m_dbz = p_dbz;
      end
    end else if (en) begin
      model(sx2w(A), sxw(B), p_q, p_r, p_ovf, p_dbz);
      m_valid = 1'b0;
      m_busy  = 1'b1;
      m_left  = p_dbz ? 1 : 2 * W + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc valid", valid, m_valid);
      chk("cyc Q", sxw(Q), m_q);
      chk("cyc R", sxw(R), m_r);
      chk("cyc ovf", ovf, m_ovf);
      chk("cyc dbz", dbz, m_dbz);
    end
  end

  task automatic run(input string name, input longint a, input longint b,
                     input longint eq, input longint er, input bit eovf,
                     input bit edbz, input int elat, input int glitch);
    logic [63:0] av, bv;
    int n;
    bit got;
    av = a; bv = b;
    @(negedge clk);
    A = av[2*W-1:0]; B = bv[W-1:0]; en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    chk({name, " valid drop"}, valid, 0);
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (glitch != 0 && n == glitch) begin
        en = 1'b1; A = 20'd5; B = 10'd1;
      end else begin
        en = 1'b0;
      end
      if (valid) got = 1'b1;
    end
    chk({name, " latency"}, n, elat);
    chk({name, " Q"}, sxw(Q), eq);
    chk({name, " R"}, sxw(R), er);
    chk({name, " ovf"}, ovf, eovf);
    chk({name, " dbz"}, dbz, edbz);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("reset valid", valid, 0);
    chk("reset Q", sxw(Q), 0);
    chk("reset R", sxw(R), 0);
    chk("reset ovf", ovf, 0);
    chk("reset dbz", dbz, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    run("pos/pos",   1000,  7,  142,  6, 1'b0, 1'b0, 21, 0);
    run("neg/pos",  -1000,  7, -142, -6, 1'b0, 1'b0, 21, 0);
    run("pos/neg",   1000, -7, -142,  6, 1'b0, 1'b0, 21, 0);
    run("neg/neg",  -1000, -7,  142, -6, 1'b0, 1'b0, 21, 0);
    run("div0",       123,  0,    0,  0, 1'b0, 1'b1,  1, 0);
`ifdef SIGNED_DIV_SAT_EN
    run("ovf600",     600,  1,  511,  0, 1'b1, 1'b0, 21, 0);
`else
    run("ovf600",     600,  1, -424,  0, 1'b1, 1'b0, 21, 0);
`endif
    run("minq",      -512,  1, -512,  0, 1'b0, 1'b0, 21, 0);
    run("roundtrip", 262144, -512, -512, 0, 1'b0, 1'b0, 21, 0);
    run("en glitch",  1000,  7,  142,  6, 1'b0, 1'b0, 21, 3);

    // Abort mid-CALC: outputs must clear without waiting for a clock.
    @(negedge clk);
    A = 20'd1000; B = 10'd7; en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort valid", valid, 0);
    chk("abort Q", sxw(Q), 0);
    chk("abort R", sxw(R), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run("post reset", -1000, 7, -142, -6, 1'b0, 1'b0, 21, 0);

    // en held high across DONE: back-to-back restarts, checked cycle by cycle.
    @(negedge clk);
    A = 20'd777; B = 10'h3F6; en = 1'b1;
    repeat (2 * (2 * W + 2) + 3) @(negedge clk);
    en = 1'b0;
    repeat (2 * W + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
